// File: rtl/report_sched.sv
// Report line sequencer: formats up to six snapshotted measurement fields as
// uppercase hex ASCII with separators and CR/LF, one byte per ready/valid transfer.
module report_sched #(
    parameter logic [7:0] SEP    = 8'h2C,
    parameter int         DROP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [29:0]       i_ph1,
    input  logic [29:0]       i_ph2,
    input  logic [29:0]       i_ph3,
    input  logic [29:0]       i_ph4,
    input  logic [29:0]       i_ph5,
    input  logic [27:0]       i_freq,
    input  logic [5:0]        i_ch_en,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic [DROP_W-1:0] o_drop_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_SEP   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, n};
        end else begin
            hex_ascii = 8'h41 + {4'h0, n} - 8'd10;
        end
    endfunction

    function automatic logic [3:0] nibble_of(input logic [31:0] v, input logic [2:0] n);
        nibble_of = v[{n, 2'b00} +: 4];
    endfunction

    // Lowest enabled field index at or above 'from'; bit 3 flags that one exists.
    function automatic logic [3:0] find_en(input logic [5:0] en, input logic [2:0] from);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 5; i >= 0; i--) begin
            r = (en[i] && (3'(i) >= from)) ? {1'b1, 3'(i)} : r;
        end
        return r;
    endfunction

    state_t              state_r, state_nx_s;
    logic [31:0]         in_vals_s [6];
    logic [31:0]         snap_r    [6];
    logic [5:0]          en_r;
    logic [2:0]          field_r, field_nx_s;
    logic [2:0]          nib_r, nib_nx_s, nib_dec_s;
    logic [7:0]          tx_data_r, tx_data_nx_s;
    logic                tx_valid_r, tx_valid_nx_s;
    logic [DROP_W-1:0]   drop_r;
    logic                xfer_s, accept_s;
    logic [3:0]          first_s, next_s;

    assign in_vals_s[0] = {2'b00, i_ph1};
    assign in_vals_s[1] = {2'b00, i_ph2};
    assign in_vals_s[2] = {2'b00, i_ph3};
    assign in_vals_s[3] = {2'b00, i_ph4};
    assign in_vals_s[4] = {2'b00, i_ph5};
    assign in_vals_s[5] = {4'h0, i_freq};

    assign xfer_s    = tx_valid_r & i_tx_ready;
    assign accept_s  = (state_r == ST_IDLE) & i_start & (i_ch_en != 6'd0);
    assign first_s   = find_en(i_ch_en, 3'd0);
    assign next_s    = find_en(en_r, field_r + 3'd1);
    assign nib_dec_s = nib_r - 3'd1;

    // Next-state and next-byte selection; the byte is registered so it is ready
    // the cycle after each transfer.
    always_comb begin
        state_nx_s    = state_r;
        field_nx_s    = field_r;
        nib_nx_s      = nib_r;
        tx_data_nx_s  = tx_data_r;
        tx_valid_nx_s = tx_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s    = ST_DIGIT;
                    field_nx_s    = first_s[2:0];
                    nib_nx_s      = 3'd7;
                    tx_valid_nx_s = 1'b1;
                    tx_data_nx_s  = hex_ascii(nibble_of(in_vals_s[first_s[2:0]], 3'd7));
                end else begin
                    tx_valid_nx_s = 1'b0;
                end
            end
            ST_DIGIT: begin
                if (xfer_s && (nib_r == 3'd0)) begin
                    if (next_s[3]) begin
                        state_nx_s   = ST_SEP;
                        field_nx_s   = next_s[2:0];
                        tx_data_nx_s = SEP;
                    end else begin
                        state_nx_s   = ST_CR;
                        tx_data_nx_s = 8'h0D;
                    end
                end else if (xfer_s) begin
                    nib_nx_s     = nib_dec_s;
                    tx_data_nx_s = hex_ascii(nibble_of(snap_r[field_r], nib_dec_s));
                end else begin
                    tx_data_nx_s = tx_data_r;
                end
            end
            ST_SEP: begin
                if (xfer_s) begin
                    state_nx_s   = ST_DIGIT;
                    nib_nx_s     = 3'd7;
                    tx_data_nx_s = hex_ascii(nibble_of(snap_r[field_r], 3'd7));
                end else begin
                    tx_data_nx_s = tx_data_r;
                end
            end
            ST_CR: begin
                if (xfer_s) begin
                    state_nx_s   = ST_LF;
                    tx_data_nx_s = 8'h0A;
                end else begin
                    tx_data_nx_s = tx_data_r;
                end
            end
            ST_LF: begin
                if (xfer_s) begin
                    state_nx_s    = ST_IDLE;
                    tx_valid_nx_s = 1'b0;
                    tx_data_nx_s  = 8'h00;
                end else begin
                    tx_data_nx_s = tx_data_r;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                tx_valid_nx_s = 1'b0;
                tx_data_nx_s  = 8'h00;
            end
        endcase
    end

    // State, output byte and sequencing registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            field_r    <= 3'd0;
            nib_r      <= 3'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            field_r    <= field_nx_s;
            nib_r      <= nib_nx_s;
            tx_data_r  <= tx_data_nx_s;
            tx_valid_r <= tx_valid_nx_s;
        end
    end

    // Snapshot of field values and mask, frozen for the whole line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_r <= 6'd0;
            for (int k = 0; k < 6; k++) begin
                snap_r[k] <= 32'd0;
            end
        end else if (accept_s) begin
            en_r <= i_ch_en;
            for (int k = 0; k < 6; k++) begin
                snap_r[k] <= in_vals_s[k];
            end
        end else begin
            en_r <= en_r;
        end
    end

    // Saturating count of starts arriving while a line is in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_r <= {DROP_W{1'b0}};
        end else if (i_start && (state_r != ST_IDLE) && (drop_r != {DROP_W{1'b1}})) begin
            drop_r <= drop_r + {{(DROP_W-1){1'b0}}, 1'b1};
        end else begin
            drop_r <= drop_r;
        end
    end

    assign o_tx_data  = tx_data_r;
    assign o_tx_valid = tx_valid_r;
    assign o_busy     = (state_r != ST_IDLE);
    assign o_drop_cnt = drop_r;

endmodule

// File: tb/tb_report_sched.sv
// Scoreboard bench for report_sched: a line-level reference model pushes the
// expected bytes; a negedge monitor pops and compares each transferred byte.
module tb_report_sched;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [29:0] ph_v [5];
    logic [27:0] freq_v = 28'd0;
    logic [5:0]  en_v = 6'd0;
    logic        i_tx_ready = 1'b1;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic [7:0]  o_drop_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic        busy_m = 1'b0;
    int          rem_m = 0;
    logic [7:0]  drop_m = 8'd0;
    logic        mon_en = 1'b0;

    report_sched #(.SEP(8'h2C), .DROP_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_ph1(ph_v[0]), .i_ph2(ph_v[1]), .i_ph3(ph_v[2]), .i_ph4(ph_v[3]), .i_ph5(ph_v[4]),
        .i_freq(freq_v), .i_ch_en(en_v),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Builds the whole expected line from the current inputs; returns its length.
    function automatic int push_line();
        logic [31:0] v [6];
        string       hexd;
        int          n;
        bit          first;
        hexd = "0123456789ABCDEF";
        n = 0;
        first = 1'b1;
        for (int f = 0; f < 5; f++) v[f] = {2'b00, ph_v[f]};
        v[5] = {4'h0, freq_v};
        for (int f = 0; f < 6; f++) begin
            if (en_v[f]) begin
                if (!first) begin
                    exp_q.push_back(8'h2C);
                    n++;
                end
                first = 1'b0;
                for (int k = 7; k >= 0; k--) begin
                    exp_q.push_back(hexd[int'((v[f] >> (4 * k)) & 32'hF)]);
                    n++;
                end
            end
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        return n + 2;
    endfunction

    // Reference model: line busy from acceptance until the last byte is taken.
    always @(posedge i_clk) begin
        if (i_rst) begin
            busy_m <= 1'b0;
            rem_m  <= 0;
            drop_m <= 8'd0;
            exp_q.delete();
        end else if (busy_m) begin
            if (i_start && drop_m != 8'hFF) drop_m <= drop_m + 8'd1;
            if (i_tx_ready) begin
                rem_m <= rem_m - 1;
                if (rem_m == 1) busy_m <= 1'b0;
            end
        end else if (i_start && en_v != 6'd0) begin
            busy_m <= 1'b1;
            rem_m  <= push_line();
        end
    end

    // Monitor: compares handshake state every cycle and pops on each transfer.
    always @(negedge i_clk) begin
        if (mon_en) begin
            checks++;
            if (o_tx_valid !== busy_m) begin
                failures++;
                $display("FAIL valid: got %0b expected %0b at %0t", o_tx_valid, busy_m, $time);
            end
            checks++;
            if (o_busy !== busy_m) begin
                failures++;
                $display("FAIL busy: got %0b expected %0b at %0t", o_busy, busy_m, $time);
            end
            checks++;
            if (o_drop_cnt !== drop_m) begin
                failures++;
                $display("FAIL drop_cnt: got %0d expected %0d at %0t", o_drop_cnt, drop_m, $time);
            end
            if (o_tx_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL byte: got %h expected none at %0t", o_tx_data, $time);
                end else begin
                    if (o_tx_data !== exp_q[0]) begin
                        failures++;
                        $display("FAIL byte: got %h expected %h at %0t", o_tx_data, exp_q[0], $time);
                    end
                    if (i_tx_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready/starts/inputs; 2: start held high.
    task automatic wait_idle(input int mode);
        int n;
        n = 0;
        while (busy_m && n < 3000) begin
            if (mode == 1) begin
                i_tx_ready = ($urandom_range(0, 3) != 0);
                i_start    = ($urandom_range(0, 9) == 0);
                for (int f = 0; f < 5; f++) ph_v[f] = 30'($urandom);
                freq_v = 28'($urandom);
            end else begin
                i_tx_ready = 1'b1;
                i_start    = (mode == 2);
            end
            step(1);
            n++;
        end
        i_start = 1'b0;
        i_tx_ready = 1'b1;
        chk("line_timeout", {31'd0, busy_m}, 32'd0);
    endtask

    initial begin
        for (int f = 0; f < 5; f++) ph_v[f] = 30'd0;
        step(3);
        i_rst = 1'b0;
        chk("rst_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("rst_data", {24'd0, o_tx_data}, 32'h00);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
        mon_en = 1'b1;

        // Single field line
        ph_v[0] = 30'h0000_1234; en_v = 6'b000001;
        pulse_start();
        chk("first_byte", {24'd0, o_tx_data}, 32'h30);
        wait_idle(0);

        // Back-pressure held at byte 3
        pulse_start();
        step(3);
        i_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, o_tx_valid}, 32'd1);
            chk("hold_data", {24'd0, o_tx_data}, 32'h30);
            step(1);
        end
        i_tx_ready = 1'b1;
        wait_idle(0);

        // Two fields with separator
        ph_v[0] = 30'h3FFF_FFFF; freq_v = 28'hABC_DEF0; en_v = 6'b100001;
        pulse_start();
        wait_idle(0);
        chk("busy_after_lf", {31'd0, o_busy}, 32'd0);

        // Start held through a whole line, including the LF transfer cycle
        en_v = 6'b000001;
        i_start = 1'b1;
        step(1);
        wait_idle(2);
        chk("drop_lf", {24'd0, o_drop_cnt}, 32'd10);

        // Saturation of the dropped-start counter
        do_reset();
        en_v = 6'h3F;
        for (int f = 0; f < 5; f++) ph_v[f] = 30'($urandom);
        pulse_start();
        i_tx_ready = 1'b0;
        i_start = 1'b1;
        step(300);
        i_start = 1'b0;
        chk("drop_sat", {24'd0, o_drop_cnt}, 32'd255);
        wait_idle(0);

        // Empty mask ignored
        do_reset();
        en_v = 6'd0;
        pulse_start();
        step(2);
        chk("en0_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("en0_drop", {24'd0, o_drop_cnt}, 32'd0);

        // Reset mid-line with coincident start, then a fresh line
        ph_v[0] = 30'h3FFF_FFFF; freq_v = 28'hABC_DEF0; en_v = 6'b100001;
        pulse_start();
        step(4);
        i_start = 1'b1;
        do_reset();
        i_start = 1'b0;
        chk("abort_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        step(1);
        pulse_start();
        wait_idle(0);

        // Randomized lines with back-pressure, stray starts and input churn
        for (int t = 0; t < 40; t++) begin
            for (int f = 0; f < 5; f++) ph_v[f] = 30'($urandom);
            freq_v = 28'($urandom);
            en_v = 6'($urandom_range(0, 63));
            pulse_start();
            wait_idle(1);
            step(1);
        end

        step(2);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
